hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/flush/drain control for a 5-stage pipeline, tracking in-flight writes in a 3-entry
// scoreboard. Build macro HAZARD_FORWARD_EN selects full forwarding (only load-use stalls).
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [2:0] id_rs,
  input  logic [2:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_regWrite,
  input  logic       id_memRead,
  input  logic       id_halt,
  input  logic [2:0] id_write_reg,
  input  logic       ex_branch_taken,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       bubble_id_ex,
  output logic       flush_if_id,
  output logic       halt_done,
  output logic [7:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       load;
    logic [2:0] rd;
  } sb_entry_t;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted
  } state_e;

  state_e    state_q, state_d, state_eff;
  sb_entry_t ex_q, mem_q, wb_q;
  sb_entry_t ex_d;
  sb_entry_t ex_eff, mem_eff, wb_eff;
  logic [7:0] cnt_q, cnt_d;

  logic ex_match;
  logic hazard;
  logic issue;
  logic sb_empty;
  logic unused_sb;

  function automatic logic src_match(input sb_entry_t e, input logic uses,
                                     input logic [2:0] r);
    return uses && e.valid && e.wr && (e.rd == r);
  endfunction

  // Reset is sampled on the clock, but its effect on outputs is immediate so an aborted
  // stall or drain leaves nothing behind during the reset cycle itself.
  always_comb begin
    state_eff = rst ? StRun : state_q;
    ex_eff    = rst ? '0 : ex_q;
    mem_eff   = rst ? '0 : mem_q;
    wb_eff    = rst ? '0 : wb_q;
  end

  assign ex_match = src_match(ex_eff, id_uses_rs, id_rs) ||
                    src_match(ex_eff, id_uses_rt, id_rt);

`ifdef HAZARD_FORWARD_EN
  assign hazard    = id_valid && ex_match && ex_eff.load;
  assign unused_sb = ^{mem_eff.wr, mem_eff.load, mem_eff.rd, wb_eff.wr, wb_eff.load, wb_eff.rd};
`else
  logic mem_match;
  assign mem_match = src_match(mem_eff, id_uses_rs, id_rs) ||
                     src_match(mem_eff, id_uses_rt, id_rt);
  assign hazard    = id_valid && (ex_match || mem_match);
  assign unused_sb = ^{ex_eff.load, mem_eff.load, wb_eff.wr, wb_eff.load, wb_eff.rd};
`endif

  assign issue    = (state_eff == StRun) && id_valid && !hazard && !ex_branch_taken;
  assign sb_empty = !ex_eff.valid && !mem_eff.valid && !wb_eff.valid;

  // A HALT has no register effect, so it does not occupy a scoreboard slot; the drain only
  // waits for the instructions ahead of it.
  always_comb begin
    ex_d = '0;
    if (issue && !id_halt) begin
      ex_d.valid = 1'b1;
      ex_d.wr    = id_regWrite;
      ex_d.load  = id_memRead;
      ex_d.rd    = id_write_reg;
    end
  end

  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    halt_done    = 1'b0;
    state_d      = state_eff;
    cnt_d        = cnt_q;
    unique case (state_eff)
      StRun: begin
        if (ex_branch_taken) begin
          flush_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
        end else if (hazard) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (issue && id_halt) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (ex_branch_taken) begin
          // The HALT sat on a mispredicted path; resume normal flow.
          flush_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
          state_d      = StRun;
        end else begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
          if (sb_empty) begin
            state_d = StHalted;
          end
        end
      end
      StHalted: begin
        halt_done    = 1'b1;
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  assign stall_cnt = rst ? 8'h00 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl; expectations follow HAZARD_FORWARD_EN when defined.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rs, id_rt;
  logic       id_uses_rs, id_uses_rt;
  logic       id_regWrite, id_memRead, id_halt;
  logic [2:0] id_write_reg;
  logic       ex_branch_taken;
  logic       stall_pc, stall_if_id, bubble_id_ex, flush_if_id, halt_done;
  logic [7:0] stall_cnt;
  logic [4:0] obs_o;

  hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_regWrite     (id_regWrite),
    .id_memRead      (id_memRead),
    .id_halt         (id_halt),
    .id_write_reg    (id_write_reg),
    .ex_branch_taken (ex_branch_taken),
    .stall_pc        (stall_pc),
    .stall_if_id     (stall_if_id),
    .bubble_id_ex    (bubble_id_ex),
    .flush_if_id     (flush_if_id),
    .halt_done       (halt_done),
    .stall_cnt       (stall_cnt)
  );

  assign obs_o = {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, halt_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urs;
    logic       urt;
    logic       rw;
    logic       mr;
    logic       hl;
    logic [2:0] wr;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic [4:0] o;
    logic [4:0] m;
    logic [7:0] cnt;
  } exp_t;

  // Output vector order: stall_pc, stall_if_id, bubble_id_ex, flush_if_id, halt_done.
  localparam logic [4:0] ON   = 5'b00000;
  localparam logic [4:0] OS   = 5'b11100;
  localparam logic [4:0] OF   = 5'b00110;
  localparam logic [4:0] OH   = 5'b10101;
  localparam logic [4:0] MALL = 5'b11111;
  localparam logic [4:0] MH   = 5'b10111;
  localparam stim_t      NOP  = '0;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic stim_t alu(input logic [2:0] wr, input logic urs, input logic [2:0] rs,
                                input logic urt, input logic [2:0] rt);
    stim_t s;
    s     = '0;
    s.v   = 1'b1;
    s.rw  = 1'b1;
    s.wr  = wr;
    s.urs = urs;
    s.rs  = rs;
    s.urt = urt;
    s.rt  = rt;
    return s;
  endfunction

  function automatic stim_t ld(input logic [2:0] wr, input logic urs, input logic [2:0] rs);
    stim_t s;
    s    = alu(wr, urs, rs, 1'b0, 3'd0);
    s.mr = 1'b1;
    return s;
  endfunction

  function automatic stim_t halt_i();
    stim_t s;
    s    = '0;
    s.v  = 1'b1;
    s.hl = 1'b1;
    return s;
  endfunction

  function automatic stim_t store_i(input logic [2:0] wr);
    stim_t s;
    s    = '0;
    s.v  = 1'b1;
    s.wr = wr;
    return s;
  endfunction

  function automatic stim_t bub(input stim_t s);
    stim_t t;
    t   = s;
    t.v = 1'b0;
    return t;
  endfunction

  function automatic stim_t redir(input stim_t s);
    stim_t t;
    t    = s;
    t.br = 1'b1;
    return t;
  endfunction

  function automatic stim_t in_rst(input stim_t s);
    stim_t t;
    t     = s;
    t.rst = 1'b1;
    return t;
  endfunction

  task automatic apply(input stim_t s);
    rst             = s.rst;
    id_valid        = s.v;
    id_rs           = s.rs;
    id_rt           = s.rt;
    id_uses_rs      = s.urs;
    id_uses_rt      = s.urt;
    id_regWrite     = s.rw;
    id_memRead      = s.mr;
    id_halt         = s.hl;
    id_write_reg    = s.wr;
    ex_branch_taken = s.br;
  endtask

  task automatic do_reset();
    apply(in_rst(NOP));
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    stim_t      st[5];
    logic [4:0] eo[5];
    exp_t       e;
    st = '{in_rst(NOP), in_rst(redir(NOP)), in_rst(alu(3'd2, 1'b1, 3'd1, 1'b0, 3'd0)),
           NOP, alu(3'd1, 1'b0, 3'd0, 1'b0, 3'd0)};
    eo = '{ON, OF, ON, ON, ON};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      sb.push_back('{o: eo[i], m: MALL, cnt: 8'd0});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({obs_o & e.m, stall_cnt} !== {e.o & e.m, e.cnt}) begin
        bad++;
        $display("FAIL reset[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", i, obs_o,
                 stall_cnt, e.o, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_raw_alu();
    stim_t      st[16];
    logic [4:0] eo[16];
    logic [7:0] ec[16];
    exp_t       e;
    do_reset();
    st = '{alu(3'd1, 1'b0, 3'd0, 1'b0, 3'd0), alu(3'd2, 1'b1, 3'd1, 1'b0, 3'd0),
           alu(3'd2, 1'b1, 3'd1, 1'b0, 3'd0), alu(3'd2, 1'b1, 3'd1, 1'b0, 3'd0), NOP,
           alu(3'd4, 1'b0, 3'd0, 1'b0, 3'd0), bub(alu(3'd1, 1'b1, 3'd4, 1'b1, 3'd4)),
           alu(3'd5, 1'b0, 3'd4, 1'b0, 3'd4), alu(3'd6, 1'b1, 3'd7, 1'b1, 3'd3),
           store_i(3'd1), alu(3'd2, 1'b1, 3'd1, 1'b0, 3'd0), NOP,
           alu(3'd7, 1'b0, 3'd0, 1'b0, 3'd0), alu(3'd1, 1'b0, 3'd0, 1'b1, 3'd7),
           alu(3'd1, 1'b0, 3'd0, 1'b1, 3'd7), alu(3'd1, 1'b0, 3'd0, 1'b1, 3'd7)};
`ifdef HAZARD_FORWARD_EN
    eo = '{ON, ON, ON, ON, ON, ON, ON, ON, ON, ON, ON, ON, ON, ON, ON, ON};
    ec = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    eo = '{ON, OS, OS, ON, ON, ON, ON, ON, ON, ON, ON, ON, ON, OS, OS, ON};
    ec = '{0, 0, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 4};
`endif
    for (int i = 0; i < 16; i++) begin
      apply(st[i]);
      sb.push_back('{o: eo[i], m: MALL, cnt: ec[i]});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({obs_o & e.m, stall_cnt} !== {e.o & e.m, e.cnt}) begin
        bad++;
        $display("FAIL raw_alu[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", i, obs_o,
                 stall_cnt, e.o, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t      st[14];
    logic [4:0] eo[14];
    logic [7:0] ec[14];
    exp_t       e;
    do_reset();
    st = '{ld(3'd3, 1'b0, 3'd0), alu(3'd4, 1'b0, 3'd0, 1'b1, 3'd3),
           alu(3'd4, 1'b0, 3'd0, 1'b1, 3'd3), alu(3'd4, 1'b0, 3'd0, 1'b1, 3'd3), NOP,
           ld(3'd5, 1'b0, 3'd0), NOP, alu(3'd6, 1'b1, 3'd5, 1'b0, 3'd0),
           alu(3'd6, 1'b1, 3'd5, 1'b0, 3'd0), ld(3'd2, 1'b0, 3'd0), NOP, NOP,
           alu(3'd1, 1'b1, 3'd2, 1'b0, 3'd0), NOP};
`ifdef HAZARD_FORWARD_EN
    eo = '{ON, OS, ON, ON, ON, ON, ON, ON, ON, ON, ON, ON, ON, ON};
    ec = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`else
    eo = '{ON, OS, OS, ON, ON, ON, ON, OS, ON, ON, ON, ON, ON, ON};
    ec = '{0, 0, 1, 2, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3};
`endif
    for (int i = 0; i < 14; i++) begin
      apply(st[i]);
      sb.push_back('{o: eo[i], m: MALL, cnt: ec[i]});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({obs_o & e.m, stall_cnt} !== {e.o & e.m, e.cnt}) begin
        bad++;
        $display("FAIL load_use[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", i, obs_o,
                 stall_cnt, e.o, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_override();
    stim_t      st[6];
    logic [4:0] eo[6];
    exp_t       e;
    do_reset();
    st = '{ld(3'd1, 1'b0, 3'd0), redir(alu(3'd2, 1'b1, 3'd1, 1'b0, 3'd0)),
           alu(3'd3, 1'b1, 3'd2, 1'b0, 3'd0), NOP, redir(alu(3'd6, 1'b0, 3'd0, 1'b0, 3'd0)),
           NOP};
    eo = '{ON, OF, ON, ON, OF, ON};
    for (int i = 0; i < 6; i++) begin
      apply(st[i]);
      sb.push_back('{o: eo[i], m: MALL, cnt: 8'd0});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({obs_o & e.m, stall_cnt} !== {e.o & e.m, e.cnt}) begin
        bad++;
        $display("FAIL branch[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", i, obs_o,
                 stall_cnt, e.o, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_drain();
    stim_t      st[10];
    logic [4:0] eo[10];
    logic [4:0] em[10];
    exp_t       e;
    do_reset();
    st = '{alu(3'd1, 1'b0, 3'd0, 1'b0, 3'd0), alu(3'd2, 1'b0, 3'd0, 1'b0, 3'd0), halt_i(),
           alu(3'd7, 1'b1, 3'd2, 1'b0, 3'd0), alu(3'd7, 1'b1, 3'd2, 1'b0, 3'd0),
           alu(3'd7, 1'b1, 3'd2, 1'b0, 3'd0), alu(3'd7, 1'b1, 3'd2, 1'b0, 3'd0), NOP,
           redir(NOP), NOP};
    eo = '{ON, ON, ON, OS, OS, OS, OH, OH, OH, OH};
    em = '{MALL, MALL, MALL, MALL, MALL, MALL, MH, MH, MH, MH};
    for (int i = 0; i < 10; i++) begin
      apply(st[i]);
      sb.push_back('{o: eo[i], m: em[i], cnt: 8'd0});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({obs_o & e.m, stall_cnt} !== {e.o & e.m, e.cnt}) begin
        bad++;
        $display("FAIL halt_drain[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d (mask %b)",
                 i, obs_o, stall_cnt, e.o, e.cnt, e.m);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drain_redirect();
    stim_t      st[7];
    logic [4:0] eo[7];
    exp_t       e;
    do_reset();
    st = '{alu(3'd1, 1'b0, 3'd0, 1'b0, 3'd0), halt_i(), redir(NOP), NOP,
           alu(3'd3, 1'b0, 3'd0, 1'b0, 3'd0), NOP, NOP};
    eo = '{ON, ON, OF, ON, ON, ON, ON};
    for (int i = 0; i < 7; i++) begin
      apply(st[i]);
      sb.push_back('{o: eo[i], m: MALL, cnt: 8'd0});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({obs_o & e.m, stall_cnt} !== {e.o & e.m, e.cnt}) begin
        bad++;
        $display("FAIL drain_redirect[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", i,
                 obs_o, stall_cnt, e.o, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort();
    stim_t      st[10];
    logic [4:0] eo[10];
    exp_t       e;
    do_reset();
    st = '{ld(3'd1, 1'b0, 3'd0), alu(3'd2, 1'b1, 3'd1, 1'b0, 3'd0),
           in_rst(alu(3'd2, 1'b1, 3'd1, 1'b0, 3'd0)), alu(3'd2, 1'b1, 3'd1, 1'b0, 3'd0),
           halt_i(), NOP, in_rst(NOP), NOP, alu(3'd4, 1'b0, 3'd0, 1'b0, 3'd0), NOP};
    eo = '{ON, OS, ON, ON, ON, OS, ON, ON, ON, ON};
    for (int i = 0; i < 10; i++) begin
      apply(st[i]);
      sb.push_back('{o: eo[i], m: MALL, cnt: 8'd0});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({obs_o & e.m, stall_cnt} !== {e.o & e.m, e.cnt}) begin
        bad++;
        $display("FAIL reset_abort[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", i,
                 obs_o, stall_cnt, e.o, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  // A self-dependent load stream stalls on every follower: issue then P-1 stall cycles.
  task automatic test_saturate();
    stim_t      s;
    stim_t      tail[4];
    logic [4:0] tail_o[4];
    logic [7:0] tail_c[4];
    int         per;
    int         ncyc;
    int         stalls;
    exp_t       e;
    do_reset();
`ifdef HAZARD_FORWARD_EN
    per = 2;
`else
    per = 3;
`endif
    ncyc   = 300 + 300 / (per - 1);
    stalls = 0;
    s      = ld(3'd3, 1'b1, 3'd3);
    for (int i = 0; i < ncyc; i++) begin
      apply(s);
      sb.push_back('{o: ((i % per) == 0) ? ON : OS, m: MALL,
                     cnt: (stalls > 255) ? 8'hFF : 8'(stalls)});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({obs_o & e.m, stall_cnt} !== {e.o & e.m, e.cnt}) begin
        bad++;
        $display("FAIL saturate[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", i, obs_o,
                 stall_cnt, e.o, e.cnt);
      end
      if ((i % per) != 0) stalls++;
      @(posedge clk); #1;
    end
    tail   = '{in_rst(s), s, s, NOP};
    tail_o = '{ON, ON, OS, ON};
    tail_c = '{8'd0, 8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 4; i++) begin
      apply(tail[i]);
      sb.push_back('{o: tail_o[i], m: MALL, cnt: tail_c[i]});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({obs_o & e.m, stall_cnt} !== {e.o & e.m, e.cnt}) begin
        bad++;
        $display("FAIL saturate_reset[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", i,
                 obs_o, stall_cnt, e.o, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    apply(in_rst(NOP));
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_raw_alu();
    test_load_use();
    test_branch_override();
    test_halt_drain();
    test_drain_redirect();
    test_reset_abort();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
